// File: rtl/des_pkg.sv
// Shared DES permutation definitions.
// Contents:
//   perm_mode_t - runtime permutation select (IP, FP, SWAP_FP, PASS).
//   IP_TABLE    - DES initial permutation, 1-based MSB-first positions.
//   FP_TABLE    - DES final permutation (inverse of IP), same numbering.
// Table entry j gives the input DES bit that lands on output DES bit j+1.
// DES bit p lives in vector bit 64-p, so DES bit 1 is bit 63.
package des_pkg;

  typedef enum logic [1:0] {
    IP      = 2'b00,
    FP      = 2'b01,
    SWAP_FP = 2'b10,
    PASS    = 2'b11
  } perm_mode_t;

  localparam int unsigned IP_TABLE [0:63] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int unsigned FP_TABLE [0:63] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

endpackage

// File: rtl/des_perm_core.sv
// Combinational 64-bit DES permutation.
// Ports:
//   data_i [63:0] - input block, bit 63 is DES bit 1.
//   mode_i        - IP, FP, SWAP_FP (swap 32-bit halves, then FP), PASS.
//   data_o [63:0] - permuted block.
// Pure wiring plus a 4:1 select; kept standalone so other permutation
// paths can reuse it.
module des_perm_core
  import des_pkg::*;
(
  input  logic [63:0] data_i,
  input  perm_mode_t  mode_i,
  output logic [63:0] data_o
);

  logic [63:0] swap_w;
  logic [63:0] ip_w;
  logic [63:0] fp_w;
  logic [63:0] sfp_w;

  assign swap_w = {data_i[31:0], data_i[63:32]};

  for (genvar g = 0; g < 64; g++) begin : g_bit
    // Output DES bit g+1 (vector bit 63-g) takes input DES bit TABLE[g]
    // (vector bit 64-TABLE[g]).
    localparam int unsigned IP_SRC = 64 - IP_TABLE[g];
    localparam int unsigned FP_SRC = 64 - FP_TABLE[g];
    assign ip_w[63-g]  = data_i[IP_SRC];
    assign fp_w[63-g]  = data_i[FP_SRC];
    assign sfp_w[63-g] = swap_w[FP_SRC];
  end

  always_comb begin
    data_o = data_i;
    case (mode_i)
      IP:      data_o = ip_w;
      FP:      data_o = fp_w;
      SWAP_FP: data_o = sfp_w;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined DES permutation stage with valid/ready handshake and tag.
// Parameters:
//   STAGES (1..4) - register stages, equal to latency without backpressure.
//   TAG_W (1..16) - sideband tag width.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset.
//   flush               - synchronous drop of every in-flight word.
//   in_valid/in_ready   - input handshake; in_data, in_mode, in_tag payload.
//   out_valid/out_ready - output handshake; out_left = result[63:32],
//                         out_right = result[31:0], out_tag.
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both 1. A producer holds valid and payload steady
// until that edge; ready may depend combinationally on the other side.
// Here in_ready is combinational from out_ready through the stage chain.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_left,
  output logic [31:0]      out_right,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [63:0]       data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];

  // What each stage would capture: stage 0 takes the permuted input,
  // stage k takes stage k-1.
  logic [STAGES-1:0] stg_valid_w;
  logic [63:0]       stg_data_w [STAGES];
  logic [TAG_W-1:0]  stg_tag_w  [STAGES];

  // rdy_w[k]: stage k may load this cycle. A stage can load when it or any
  // stage downstream of it is empty (bubbles collapse), or when the output
  // side is draining.
  logic [STAGES-1:0] rdy_w;
  logic [63:0]       perm_w;

  des_perm_core u_core (
    .data_i (in_data),
    .mode_i (perm_mode_t'(in_mode)),
    .data_o (perm_w)
  );

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign rdy_w[k] = out_ready | ~(&valid_q[LAST:k]);
    if (k == 0) begin : g_first
      assign stg_valid_w[k] = in_valid;
      assign stg_data_w[k]  = perm_w;
      assign stg_tag_w[k]   = in_tag;
    end else begin : g_next
      assign stg_valid_w[k] = valid_q[k-1];
      assign stg_data_w[k]  = data_q[k-1];
      assign stg_tag_w[k]   = tag_q[k-1];
    end
  end

  assign in_ready  = !flush && rdy_w[0];
  assign out_valid = valid_q[LAST];
  assign out_left  = data_q[LAST][63:32];
  assign out_right = data_q[LAST][31:0];
  assign out_tag   = tag_q[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (flush) begin
      // Payload registers keep stale contents; only validity is cleared.
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy_w[k]) begin
          valid_q[k] <= stg_valid_w[k];
          // Payload only moves with a real word, so a held output never
          // changes under a stall and bubbles do not toggle data.
          if (stg_valid_w[k]) begin
            data_q[k] <= stg_data_w[k];
            tag_q[k]  <= stg_tag_w[k];
          end
        end
      end
    end
  end

endmodule
